sound_sequencer: RTL and testbench
==================================

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter PLAY_CYCLES, default 10_000_000, cycles one tone plays (legal range 1..2^24-1).
REQ-002 Parameter GAP_CYCLES, default 120_000, silent cycles after each tone (0 = no gap).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 good_coll  input  1  good-collision sound request, level-sampled each cycle.
REQ-006 bad_coll  input  1  bad-collision sound request, level-sampled each cycle.
REQ-007 direction  input  4  movement input; move request = OR of all bits.
REQ-008 mute  input  1  suppresses tone_en only; sequencing continues.
REQ-009 tone_en  output  1  oscillator enable, registered.
REQ-010 freq  output  8  oscillator half-period divisor, registered.
REQ-011 active_id  output  2  0 none, 1 good, 2 bad, 3 move.
REQ-012 busy  output  1  high in PLAY or GAP.
REQ-013 done  output  1  one-cycle pulse when a tone completes its full duration.

Function
REQ-014 Divisor table: good -> 107, bad -> 151, move -> 179; freq = 0 when active_id = 0.
REQ-015 Priority: good > bad > move.
REQ-016 Three pending bits, one per sound: set on any cycle the request is high and that sound is not being granted that cycle; repeat requests merge into one pending bit.
REQ-017 States IDLE, PLAY, GAP; a 24-bit down-counter is shared by PLAY and GAP.
REQ-018 IDLE: if any (pending | current request) is set, grant the highest-priority source, clear its pending bit, load counter with PLAY_CYCLES-1, and go to PLAY; grant latency is 1 cycle (request in cycle N -> tone_en = 1 in cycle N+1).
REQ-019 PLAY: tone_en = ~mute, freq and active_id = granted sound; decrement each cycle.
REQ-020 PLAY at counter 0: pulse done for 1 cycle; if GAP_CYCLES > 0, load GAP_CYCLES-1 and go to GAP, otherwise apply the REQ-018 grant check directly (back-to-back tones).
REQ-021 GAP: tone_en = 0, freq = 0, active_id = 0, busy = 1; decrement; at counter 0, apply the REQ-018 grant check.
REQ-022 Preemption: only a move tone is preemptible; a good or bad request/pending during a move PLAY restarts PLAY next cycle with the collision sound and reloads the counter.
REQ-023 On preemption the move tone is dropped (not re-pended), no done pulse is issued, and the collision pending bit is cleared.
REQ-024 A collision tone is never preempted; requests arriving during it are pended.
REQ-025 A request for the sound currently playing sets its pending bit, so the sound replays after the gap.
REQ-026 Simultaneous good_coll and bad_coll in IDLE: grant good and pend bad.
REQ-027 A request in the same cycle as the PLAY->GAP transition is pended, not lost.
REQ-028 mute toggled mid-tone changes only tone_en on the next cycle; counter, state and done timing are unaffected.
REQ-029 The counter never underflows; no other counter wrap occurs.

Reset
REQ-030 rst high at a clock edge: state = IDLE, counter = 0, all pending bits = 0, tone_en = 0, freq = 0, active_id = 0, busy = 0, done = 0.
REQ-031 Requests present during reset are ignored and not pended; reset mid-tone aborts with no done pulse.

Verification (bench uses PLAY_CYCLES=8, GAP_CYCLES=2)
REQ-032 good_coll pulse 1 cycle in IDLE -> next cycle tone_en = 1, freq = 107, active_id = 1 for 8 cycles; done pulses on cycle 8; then 2 gap cycles; then busy = 0.
REQ-033 good_coll and bad_coll high together for 1 cycle -> good tone (107) for 8 cycles, 2 gap cycles, then bad tone (151) for 8 cycles; 2 done pulses total.
REQ-034 direction = 4'b0010 starts a move tone (179); good_coll on PLAY cycle 3 -> next cycle freq = 107 for a full 8 cycles; no done pulse for the move tone; move does not replay.
REQ-035 bad tone playing, direction nonzero on cycle 5 -> bad tone completes all 8 cycles, then gap, then move tone (179).
REQ-036 mute = 1 during cycles 2-4 of a tone -> tone_en = 0 for exactly those cycles, freq unchanged, done still pulses on cycle 8.
REQ-037 rst asserted on PLAY cycle 4 with bad pending -> next cycle all outputs 0, IDLE; with no further requests, tone_en stays 0.

Source files
------------

// File: rtl/sound_sequencer.sv
// Tone sequencer for collision and movement sounds: arbitrates three request
// sources, plays one tone at a time for PLAY_CYCLES, then holds a silent gap.
module sound_sequencer #(
   parameter int PLAY_CYCLES = 10_000_000,
   parameter int GAP_CYCLES  = 120_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       good_coll,
   input  logic       bad_coll,
   input  logic [3:0] direction,
   input  logic       mute,
   output logic       tone_en,
   output logic [7:0] freq,
   output logic [1:0] active_id,
   output logic       busy,
   output logic       done,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

   localparam logic [1:0]  ID_NONE   = 2'd0;
   localparam logic [1:0]  ID_GOOD   = 2'd1;
   localparam logic [1:0]  ID_BAD    = 2'd2;
   localparam logic [1:0]  ID_MOVE   = 2'd3;
   localparam logic [23:0] PLAY_LOAD = 24'(PLAY_CYCLES - 1);
   localparam logic [23:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 24'(GAP_CYCLES - 1) : 24'd0;
   localparam logic        HAS_GAP   = (GAP_CYCLES > 0);

   state_t      state_q, state_n;
   logic [23:0] cnt_q, cnt_n;
   logic [1:0]  cur_q, cur_n;
   logic [2:0]  pend_q, pend_n;
   logic [2:0]  req, avail, grant_bit;
   logic [1:0]  grant, pick_id, coll_id;
   logic        tone_en_n;
   logic [7:0]  freq_n;
   logic [1:0]  active_id_n;

   // Bit 0 = good, bit 1 = bad, bit 2 = move; lower bit wins.
   always_comb begin
      req     = {|direction, bad_coll, good_coll};
      avail   = pend_q | req;
      coll_id = avail[0] ? ID_GOOD : ID_BAD;
      pick_id = avail[0] ? ID_GOOD : (avail[1] ? ID_BAD : ID_MOVE);
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      cur_n   = cur_q;
      grant   = ID_NONE;
      case (state_q)
         IDLE: if (|avail) grant = pick_id;
         PLAY: begin
            // A move tone yields to any collision sound unless it is already finishing.
            if (cur_q == ID_MOVE && cnt_q != 24'd0 && (avail[0] | avail[1]))
               grant = coll_id;
            else if (cnt_q != 24'd0)
               cnt_n = cnt_q - 24'd1;
            else if (HAS_GAP) begin
               state_n = GAP;
               cnt_n   = GAP_LOAD;
            end else if (|avail)
               grant = pick_id;
            else
               state_n = IDLE;
         end
         GAP: begin
            if (cnt_q != 24'd0)
               cnt_n = cnt_q - 24'd1;
            else if (|avail)
               grant = pick_id;
            else
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (grant != ID_NONE) begin
         state_n = PLAY;
         cnt_n   = PLAY_LOAD;
         cur_n   = grant;
      end
      grant_bit = {grant == ID_MOVE, grant == ID_BAD, grant == ID_GOOD};
      pend_n    = (pend_q | req) & ~grant_bit;
   end

   // Registered outputs are computed from the upcoming state so they line up with it.
   always_comb begin
      tone_en_n   = (state_n == PLAY) & ~mute;
      active_id_n = (state_n == PLAY) ? cur_n : ID_NONE;
      case (active_id_n)
         ID_GOOD: freq_n = 8'd107;
         ID_BAD:  freq_n = 8'd151;
         ID_MOVE: freq_n = 8'd179;
         default: freq_n = 8'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 24'd0;
         cur_q     <= ID_NONE;
         pend_q    <= 3'd0;
         tone_en   <= 1'b0;
         freq      <= 8'd0;
         active_id <= ID_NONE;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         cur_q     <= cur_n;
         pend_q    <= pend_n;
         tone_en   <= tone_en_n;
         freq      <= freq_n;
         active_id <= active_id_n;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == PLAY) && (cnt_q == 24'd0);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: a directed vector table, hand-written corner
// sequences and random traffic checked against a cycle-count reference model.
module tb_sound_sequencer;

   localparam int PLAY = 8;
   localparam int GAP  = 2;

   logic       clk = 1'b0;
   logic       rst, good_coll, bad_coll, mute;
   logic [3:0] direction;
   logic       tone_en, busy, done;
   logic [7:0] freq;
   logic [1:0] active_id, state_dbg;

   int n_vec = 0;
   int n_err = 0;

   sound_sequencer #(.PLAY_CYCLES(PLAY), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .good_coll(good_coll), .bad_coll(bad_coll),
      .direction(direction), .mute(mute), .tone_en(tone_en), .freq(freq),
      .active_id(active_id), .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 tone, 2 gap; left = cycles remaining in the phase incl. current
   int  m_ph, m_left, m_snd;
   bit  m_pend[3];
   logic [12:0] exp_q[$];

   function automatic logic [7:0] div_of(int snd);
      if (snd == 0) return 8'd107;
      if (snd == 1) return 8'd151;
      return 8'd179;
   endfunction

   task automatic model_step(input bit r, input bit g, input bit b, input bit [3:0] d, input bit m);
      bit req[3];
      int pick;
      logic e_tone, e_busy, e_done;
      logic [7:0] e_freq;
      logic [1:0] e_id;
      pick = -1;
      if (r) begin
         m_ph = 0; m_left = 0; m_snd = 0;
         for (int i = 0; i < 3; i++) m_pend[i] = 0;
      end else begin
         req[0] = g; req[1] = b; req[2] = (d != 0);
         if (m_ph == 1 && m_snd == 2 && m_left > 1) begin
            for (int i = 0; i < 2; i++) if (pick < 0 && (m_pend[i] || req[i])) pick = i;
         end else if (m_ph == 0 || (m_ph == 1 && m_left == 1 && GAP == 0) || (m_ph == 2 && m_left == 1)) begin
            for (int i = 0; i < 3; i++) if (pick < 0 && (m_pend[i] || req[i])) pick = i;
         end
         for (int i = 0; i < 3; i++) begin
            if (i == pick) m_pend[i] = 0;
            else if (req[i]) m_pend[i] = 1;
         end
         if (pick >= 0) begin
            m_ph = 1; m_snd = pick; m_left = PLAY;
         end else if (m_ph == 1) begin
            if (m_left > 1) m_left--;
            else if (GAP > 0) begin m_ph = 2; m_left = GAP; end
            else m_ph = 0;
         end else if (m_ph == 2) begin
            if (m_left > 1) m_left--;
            else m_ph = 0;
         end
      end
      e_tone = (m_ph == 1) && !m && !r;
      e_id   = (m_ph == 1) ? 2'(m_snd + 1) : 2'd0;
      e_freq = (m_ph == 1) ? div_of(m_snd) : 8'd0;
      e_busy = (m_ph != 0);
      e_done = (m_ph == 1) && (m_left == 1);
      exp_q.push_back({e_tone, e_freq, e_id, e_busy, e_done});
   endtask

   // ---------------- observation counters ----------------
   int c_done, c_f107, c_f151, c_f179, c_tone, c_busy, c_muted;

   task automatic clr_counts();
      c_done = 0; c_f107 = 0; c_f151 = 0; c_f179 = 0; c_tone = 0; c_busy = 0; c_muted = 0;
   endtask

   // ---------------- driver ----------------
   task automatic apply(input bit r, input bit g, input bit b, input bit [3:0] d, input bit m);
      @(negedge clk);
      rst = r; good_coll = g; bad_coll = b; direction = d; mute = m;
      @(posedge clk);
      model_step(r, g, b, d, m);
      #1;
      c_done  += int'(done);
      c_tone  += int'(tone_en);
      c_busy  += int'(busy);
      c_f107  += int'(freq == 8'd107);
      c_f151  += int'(freq == 8'd151);
      c_f179  += int'(freq == 8'd179);
      c_muted += int'(freq != 8'd0 && !tone_en);
   endtask

   task automatic check_vec(input string name, input logic et, input logic [7:0] ef,
                            input logic [1:0] ei, input logic eb, input logic ed);
      n_vec++;
      if (tone_en !== et || freq !== ef || active_id !== ei || busy !== eb || done !== ed) begin
         n_err++;
         $display("FAIL %s: got tone_en=%0b freq=%0d id=%0d busy=%0b done=%0b, want tone_en=%0b freq=%0d id=%0d busy=%0b done=%0b",
                  name, tone_en, freq, active_id, busy, done, et, ef, ei, eb, ed);
      end
   endtask

   // scoreboard: pop the model's expectation for this cycle
   task automatic apply_chk(input string name, input bit r, input bit g, input bit b,
                            input bit [3:0] d, input bit m);
      logic [12:0] e;
      apply(r, g, b, d, m);
      e = exp_q.pop_front();
      check_vec(name, e[12], e[11:4], e[3:2], e[1], e[0]);
   endtask

   task automatic idle_chk(input string name, input int n);
      for (int i = 0; i < n; i++) apply_chk(name, 0, 0, 0, 4'd0, 0);
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic       r, g, b;
      logic [3:0] d;
      logic       m;
      logic       et;
      logic [7:0] ef;
      logic [1:0] ei;
      logic       eb, ed;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(input logic r, input logic g, input logic et, input logic [7:0] ef,
                               input logic [1:0] ei, input logic eb, input logic ed);
      vec_t v;
      v.r = r; v.g = g; v.b = 1'b0; v.d = 4'd0; v.m = 1'b0;
      v.et = et; v.ef = ef; v.ei = ei; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   initial begin
      rst = 1'b1; good_coll = 1'b0; bad_coll = 1'b0; direction = 4'd0; mute = 1'b0;
      m_ph = 0; m_left = 0; m_snd = 0;
      clr_counts();

      // single good pulse: 8 tone cycles, done on the 8th, 2 gap cycles, idle
      tbl[0] = mk(1, 0, 0, 8'd0, 2'd0, 0, 0);
      tbl[1] = mk(0, 1, 1, 8'd107, 2'd1, 1, 0);
      for (int i = 2; i < 8; i++) tbl[i] = mk(0, 0, 1, 8'd107, 2'd1, 1, 0);
      tbl[8]  = mk(0, 0, 1, 8'd107, 2'd1, 1, 1);
      tbl[9]  = mk(0, 0, 0, 8'd0, 2'd0, 1, 0);
      tbl[10] = mk(0, 0, 0, 8'd0, 2'd0, 1, 0);
      tbl[11] = mk(0, 0, 0, 8'd0, 2'd0, 0, 0);
      tbl[12] = mk(0, 0, 0, 8'd0, 2'd0, 0, 0);
      // request held during reset is ignored
      tbl[13] = mk(1, 1, 0, 8'd0, 2'd0, 0, 0);
      tbl[14] = mk(0, 0, 0, 8'd0, 2'd0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].d, tbl[i].m);
         void'(exp_q.pop_front());
         check_vec($sformatf("table[%0d]", i), tbl[i].et, tbl[i].ef, tbl[i].ei, tbl[i].eb, tbl[i].ed);
      end

      // good and bad together: good first, bad after the gap
      clr_counts();
      apply_chk("both_req", 0, 1, 1, 4'd0, 0);
      idle_chk("both_run", 24);
      check_int("both_done_count", c_done, 2);
      check_int("both_good_cycles", c_f107, 8);
      check_int("both_bad_cycles", c_f151, 8);

      // move tone preempted by good on its 3rd cycle
      clr_counts();
      apply_chk("move_start", 0, 0, 0, 4'b0010, 0);
      idle_chk("move_play", 2);
      apply_chk("preempt_req", 0, 1, 0, 4'd0, 0);
      idle_chk("preempt_run", 20);
      check_int("preempt_move_cycles", c_f179, 3);
      check_int("preempt_good_cycles", c_f107, 8);
      check_int("preempt_done_count", c_done, 1);

      // move request during a bad tone waits for it and the gap
      clr_counts();
      apply_chk("bad_start", 0, 0, 1, 4'd0, 0);
      idle_chk("bad_play", 4);
      apply_chk("move_during_bad", 0, 0, 0, 4'b1000, 0);
      idle_chk("bad_then_move", 25);
      check_int("bad_cycles", c_f151, 8);
      check_int("queued_move_cycles", c_f179, 8);
      check_int("bad_move_dones", c_done, 2);

      // mute across tone cycles 2-4
      clr_counts();
      apply_chk("mute_start", 0, 1, 0, 4'd0, 0);
      for (int i = 0; i < 3; i++) apply_chk("mute_on", 0, 0, 0, 4'd0, 1);
      idle_chk("mute_off", 15);
      check_int("muted_cycles", c_muted, 3);
      check_int("mute_good_cycles", c_f107, 8);
      check_int("mute_done_count", c_done, 1);

      // reset on tone cycle 4 with bad pending
      clr_counts();
      apply_chk("rst_bad_start", 0, 0, 1, 4'd0, 0);
      apply_chk("rst_bad_pend", 0, 0, 1, 4'd0, 0);
      idle_chk("rst_bad_play", 2);
      apply_chk("rst_mid_tone", 1, 0, 0, 4'd0, 0);
      clr_counts();
      idle_chk("rst_after", 15);
      check_int("rst_no_tone", c_tone, 0);
      check_int("rst_no_busy", c_busy, 0);
      check_int("rst_no_done", c_done, 0);

      // random traffic against the model
      apply_chk("rand_reset", 1, 0, 0, 4'd0, 0);
      for (int i = 0; i < 800; i++) begin
         apply_chk("random", ($urandom_range(0, 99) == 0),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                   ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
